// File: rtl/cp0_exc_sequencer.sv
// CP0 commit-point sequencer: arbitrates interrupts, M-stage exceptions and ERET into one atomic entry/flush/redirect transaction.
// Optional macro CP0SEQ_STATS_EN builds saturating taken-interrupt/exception counters.
module cp0_exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  hw_int,
    input  logic [5:0]  sr_im,
    input  logic        sr_ie,
    input  logic        sr_exl,
    input  logic [31:0] epc_in,
    input  logic        m_valid,
    input  logic [4:0]  m_exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_eret,
    input  logic        pc_ack,
    output logic        cp0_exc_we,
    output logic [4:0]  cp0_exc_code,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic        cp0_exl_clr,
    output logic [5:0]  hwint_sync,
    output logic        flush_all,
    output logic        stall_req,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic [15:0] int_cnt,
    output logic [15:0] exc_cnt
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_ERET,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t                       r_state;
    logic [SYNC_STAGES-1:0][5:0]  r_sync;
    logic [CW-1:0]                r_flush_cnt;
    logic                         r_exc_we;
    logic [4:0]                   r_exc_code;
    logic [31:0]                  r_epc;
    logic                         r_bd;
    logic                         r_exl_clr;
    logic                         r_flush;
    logic                         r_stall;
    logic                         r_pc_load;
    logic [31:0]                  r_pc_target;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_take_int;
    logic        w_take_exc;
    logic        w_take_eret;
    logic [31:0] w_epc;

    // hw_int is asynchronous; only the last synchronizer stage is ever observed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], hw_int};
        end
    end

    assign hwint_sync  = r_sync[SYNC_STAGES-1];
    assign w_int_pend  = (|(hwint_sync & sr_im)) & sr_ie & ~sr_exl;
    assign w_exc_pend  = (m_exc_code != 5'd0) & ~sr_exl;
    assign w_take_int  = (r_state == S_IDLE) & m_valid & w_int_pend;
    assign w_take_exc  = (r_state == S_IDLE) & m_valid & ~w_int_pend & w_exc_pend;
    assign w_take_eret = (r_state == S_IDLE) & m_valid & ~w_int_pend & ~w_exc_pend & m_eret;
    assign w_epc       = m_bd ? (m_pc - 32'd4) : m_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
            r_exc_we    <= 1'b0;
            r_exc_code  <= '0;
            r_epc       <= '0;
            r_bd        <= 1'b0;
            r_exl_clr   <= 1'b0;
            r_flush     <= 1'b0;
            r_stall     <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
        end else begin
            r_exc_we  <= 1'b0;
            r_exl_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // An interrupt beating a coincident exception drops the exception; the instruction re-executes later.
                    if (w_take_int || w_take_exc) begin
                        r_state     <= S_ENTRY;
                        r_exc_we    <= 1'b1;
                        r_exc_code  <= w_take_int ? 5'd0 : m_exc_code;
                        r_epc       <= w_epc;
                        r_bd        <= m_bd;
                        r_pc_target <= HANDLER_ADDR;
                        r_stall     <= 1'b1;
                    end else if (w_take_eret) begin
                        r_state     <= S_ERET;
                        r_exl_clr   <= 1'b1;
                        r_pc_target <= epc_in;
                        r_stall     <= 1'b1;
                    end
                end
                S_ENTRY, S_ERET: begin
                    r_state     <= S_FLUSH;
                    r_flush     <= 1'b1;
                    r_flush_cnt <= CW'(FLUSH_CYCLES - 1);
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state   <= S_REDIRECT;
                        r_flush   <= 1'b0;
                        r_pc_load <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (pc_ack) begin
                        r_state   <= S_IDLE;
                        r_pc_load <= 1'b0;
                        r_stall   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_flush   <= 1'b0;
                    r_pc_load <= 1'b0;
                    r_stall   <= 1'b0;
                end
            endcase
        end
    end

    assign cp0_exc_we   = r_exc_we;
    assign cp0_exc_code = r_exc_code;
    assign cp0_epc      = r_epc;
    assign cp0_bd       = r_bd;
    assign cp0_exl_clr  = r_exl_clr;
    assign flush_all    = r_flush;
    assign stall_req    = r_stall;
    assign pc_load      = r_pc_load;
    assign pc_target    = r_pc_target;

`ifdef CP0SEQ_STATS_EN
    logic [15:0] r_int_cnt;
    logic [15:0] r_exc_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_cnt <= '0;
            r_exc_cnt <= '0;
        end else begin
            if (w_take_int && (r_int_cnt != 16'hFFFF)) begin
                r_int_cnt <= r_int_cnt + 16'd1;
            end
            if (w_take_exc && (r_exc_cnt != 16'hFFFF)) begin
                r_exc_cnt <= r_exc_cnt + 16'd1;
            end
        end
    end

    assign int_cnt = r_int_cnt;
    assign exc_cnt = r_exc_cnt;
`else
    assign int_cnt = 16'h0;
    assign exc_cnt = 16'h0;
`endif

endmodule
